// File: rtl/sd_response_checker.sv
// SD CMD-line response checker: validates framing bits, recomputes CRC7 bit-serially
// and extracts command index, argument and R2 payload from a latched response frame.
module sd_response_checker #(
  parameter int         FRAME_W  = 136,
  parameter logic [6:0] CRC_POLY = 7'h09
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  input  logic [7:0]         framesize,
  input  logic               crc_check,
  output logic               busy,
  output logic               done,
  output logic               format_ok,
  output logic               crc_ok,
  output logic [5:0]         cmd_index,
  output logic [31:0]        argument,
  output logic [127:0]       r2_data,
  output logic [6:0]         crc_calc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CRC   = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [7:0]         size_q, size_d;
  logic               chk_q, chk_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [6:0]         crc_q, crc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fok_q, fok_d;
  logic               cok_q, cok_d;
  logic [5:0]         idx_q, idx_d;
  logic [31:0]        arg_q, arg_d;
  logic [127:0]       r2_q, r2_d;
  logic               start_legal;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC_POLY : 7'h00);
  endfunction

  assign start_legal = (framesize == 8'd48) || (framesize == 8'd136);

  // Next-state and result computation for the IDLE/CRC/CHECK sequencer
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    size_d  = size_q;
    chk_d   = chk_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fok_d   = fok_q;
    cok_d   = cok_q;
    idx_d   = idx_q;
    arg_d   = arg_q;
    r2_d    = r2_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          frame_d = frame;
          size_d  = framesize;
          chk_d   = crc_check;
          busy_d  = 1'b1;
          crc_d   = 7'h00;
          if (start_legal && crc_check) begin
            state_d = CRC;
            cnt_d   = (framesize == 8'd48) ? 8'd47 : 8'd127;
          end else begin
            state_d = CHECK;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CRC: begin
        // Coverage ends at bit 8; bits 7:1 hold the received CRC itself
        crc_d = crc7_step(crc_q, frame_q[cnt_q]);
        if (cnt_q == 8'd8) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      CHECK: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (size_q == 8'd48) begin
          fok_d = ~frame_q[47] & ~frame_q[46] & frame_q[0];
          cok_d = chk_q ? (crc_q == frame_q[7:1]) : 1'b1;
          idx_d = frame_q[45:40];
          arg_d = frame_q[39:8];
          r2_d  = 128'h0;
        end else if (size_q == 8'd136) begin
          fok_d = ~frame_q[135] & ~frame_q[134] & (frame_q[133:128] == 6'h3F) & frame_q[0];
          cok_d = chk_q ? (crc_q == frame_q[7:1]) : 1'b1;
          idx_d = 6'h3F;
          arg_d = 32'h0;
          r2_d  = frame_q[127:0];
        end else begin
          fok_d = 1'b0;
          cok_d = 1'b0;
          idx_d = 6'h00;
          arg_d = 32'h0;
          r2_d  = 128'h0;
          crc_d = 7'h00;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      size_q  <= 8'h00;
      chk_q   <= 1'b0;
      cnt_q   <= 8'h00;
      crc_q   <= 7'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fok_q   <= 1'b0;
      cok_q   <= 1'b0;
      idx_q   <= 6'h00;
      arg_q   <= 32'h0;
      r2_q    <= 128'h0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      size_q  <= size_d;
      chk_q   <= chk_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fok_q   <= fok_d;
      cok_q   <= cok_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
      r2_q    <= r2_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign format_ok = fok_q;
  assign crc_ok    = cok_q;
  assign cmd_index = idx_q;
  assign argument  = arg_q;
  assign r2_data   = r2_q;
  assign crc_calc  = crc_q;

endmodule
